// File: rtl/dac_sched.sv
// dac_sched: sequences the audio DAC and owns the single byte-wide write
// port of its 2^BUF_AW-byte, two-half sample buffer.
//
// Ports
//   clkin, reset_n         clock, asynchronous active-low reset
//   mcu_req/addr/data/ack  MCU programming writes (fixed priority)
//   str_req/data/ack       streamer writes, address taken from wr_ptr
//   cmd_play, cmd_stop     one-cycle playback commands (stop wins)
//   dac_status             half the DAC is currently reading
//   buf_we_n/addr/data     registered buffer write port
//   dac_play, dac_reset    DAC controls
//   refill_req/half        streamer refill window and target half
//   underrun               sticky missed-refill flag, cleared by cmd_play
//   state                  0 IDLE, 1 PRIME, 2 PLAY, 3 STOP
//
// Build option: define DAC_SCHED_UNDERRUN_STOP_EN to make an underrun stop
// playback as cmd_stop does; otherwise playback continues on the retarget.
module dac_sched #(
  parameter int BUF_AW    = 11,
  parameter int RST_PULSE = 4
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              mcu_req,
  input  logic [BUF_AW-1:0] mcu_addr,
  input  logic [7:0]        mcu_data,
  output logic              mcu_ack,
  input  logic              str_req,
  input  logic [7:0]        str_data,
  output logic              str_ack,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              dac_status,
  output logic              buf_we_n,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              dac_play,
  output logic              dac_reset,
  output logic              refill_req,
  output logic              refill_half,
  output logic              underrun,
  output logic [1:0]        state
);

  localparam int CW = $clog2(RST_PULSE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_AW-1:0] wr_ptr, wr_ptr_inc;
  logic [CW-1:0]     rst_cnt;
  logic              st_q;
  logic              mcu_grant, str_grant;
  logic              status_edge, miss, start, stop_req, force_stop;
  logic              wrap, half_done;

  assign dac_play = (state_q == PLAY);
  assign state    = state_q;

  always_comb begin
    mcu_grant   = mcu_req & ~mcu_ack;
    str_grant   = str_req & ~str_ack & refill_req & ~mcu_grant;
    wr_ptr_inc  = wr_ptr + BUF_AW'(1);
    wrap        = str_grant & (wr_ptr == '1);
    half_done   = str_grant & (&wr_ptr[BUF_AW-2:0]);
    // st_q holds the previously read half, which is the one just vacated
    status_edge = (state_q == PLAY) & (dac_status ^ st_q);
    miss        = status_edge & refill_req;
    start       = (state_q == IDLE) & cmd_play & ~cmd_stop;
    stop_req    = cmd_stop & ((state_q == PRIME) | (state_q == PLAY));
`ifdef DAC_SCHED_UNDERRUN_STOP_EN
    force_stop  = stop_req | miss;
`else
    force_stop  = stop_req;
`endif
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PRIME;
      PRIME:   if (force_stop) state_d = STOP;
               else if (wrap) state_d = PLAY;
      PLAY:    if (force_stop) state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Sequencing datapath: write pointer, refill window, reset pulse, flags.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      refill_req  <= 1'b0;
      refill_half <= 1'b0;
      underrun    <= 1'b0;
      dac_reset   <= 1'b0;
      rst_cnt     <= '0;
      st_q        <= 1'b0;
    end else begin
      st_q <= dac_status;
      if (miss) underrun <= 1'b1;
      if (force_stop) begin
        refill_req <= 1'b0;
        dac_reset  <= 1'b0;
        rst_cnt    <= '0;
      end else if (start) begin
        wr_ptr      <= '0;
        underrun    <= 1'b0;
        refill_req  <= 1'b1;
        refill_half <= 1'b0;
        dac_reset   <= 1'b1;
        rst_cnt     <= CW'(RST_PULSE - 1);
      end else begin
        if (dac_reset) begin
          if (rst_cnt == '0) dac_reset <= 1'b0;
          else               rst_cnt   <= rst_cnt - CW'(1);
        end
        // A status edge retargets the pointer and overrides any increment
        // from a grant issued in the same cycle.
        if (status_edge) begin
          refill_half <= st_q;
          refill_req  <= 1'b1;
          wr_ptr      <= {st_q, {(BUF_AW-1){1'b0}}};
        end else if (str_grant) begin
          wr_ptr <= wr_ptr_inc;
          if (state_q == PRIME) begin
            refill_half <= wr_ptr_inc[BUF_AW-1];
            if (wrap) refill_req <= 1'b0;
          end else if (half_done) begin
            refill_req <= 1'b0;
          end
        end
      end
    end
  end

  // Registered write port; MCU has fixed priority.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      mcu_ack  <= 1'b0;
      str_ack  <= 1'b0;
      buf_we_n <= 1'b1;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      mcu_ack  <= mcu_grant;
      str_ack  <= str_grant;
      buf_we_n <= ~(mcu_grant | str_grant);
      if (mcu_grant) begin
        buf_addr <= mcu_addr;
        buf_data <= mcu_data;
      end else if (str_grant) begin
        buf_addr <= wr_ptr;
        buf_data <= str_data;
      end
    end
  end

endmodule
